// File: rtl/key_events_pkg.sv
// key_events_pkg: mode and FSM encodings plus parameter legality check for key_events
package key_events_pkg;
  typedef enum logic [1:0] {KM_PRESS, KM_RELEASE, KM_BOTH, KM_REPEAT} km_e;
  typedef enum logic [1:0] {ST_UP, ST_DOWN, ST_REPEAT} st_e;
  function automatic bit params_ok(int sync_stages, int debounce_cycles, int repeat_delay, int repeat_period);
    return sync_stages >= 2 && debounce_cycles >= 1 && repeat_delay >= 1 && repeat_period >= 1;
  endfunction
endpackage

// File: rtl/key_events_if.sv
// key_events_if: key pins and mode in, debounced levels and event pulses out
interface key_events_if #(parameter int N_KEYS = 4);
  logic [N_KEYS-1:0]   key;
  logic [2*N_KEYS-1:0] mode;
  logic [N_KEYS-1:0]   level;
  logic [N_KEYS-1:0]   evt;
  logic                any_evt;
  modport master (output key, mode, input level, evt, any_evt);
  modport slave  (input key, mode, output level, evt, any_evt);
endinterface

// File: rtl/key_events_channel.sv
// key_channel: one key - synchroniser, counter debounce, press/release/repeat FSM, registered pulse
module key_channel
  import key_events_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 50,
  parameter int REPEAT_PERIOD   = 10,
  parameter int ACTIVE_LOW_IN   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key,
  input  logic [1:0] mode,
  output logic       level,
  output logic       evt
);
  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  if (!params_ok(SYNC_STAGES, DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) begin : g_bad_params
    $error("key_channel: illegal parameter values");
  end
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [RW-1:0]          rcnt_q, rcnt_d;
  logic                   level_q, level_d;
  logic                   evt_q, evt_d;
  st_e                    st_q, st_d;
  logic                   s, flip, rise, fall, rep_hit;
  km_e                    m;
  // synchronise the normalised key and debounce it; level flips after DEBOUNCE_CYCLES disagreeing samples
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], key ^ (ACTIVE_LOW_IN != 0)};
    s       = sync_q[SYNC_STAGES-1];
    flip    = (s != level_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
    cnt_d   = (s == level_q || flip) ? '0 : cnt_q + CW'(1);
    level_d = level_q ^ flip;
    rise    = flip & ~level_q;
    fall    = flip & level_q;
  end
  // event FSM: release beats a coinciding repeat tick, and leaving mode 11 parks the channel in DOWN
  always_comb begin
    m       = km_e'(mode);
    st_d    = st_q;
    rcnt_d  = rcnt_q;
    evt_d   = 1'b0;
    rep_hit = (st_q == ST_DOWN) ? rcnt_q == RW'(REPEAT_DELAY - 1) : rcnt_q == RW'(REPEAT_PERIOD - 1);
    if (st_q == ST_UP) begin
      st_d   = rise ? ST_DOWN : ST_UP;
      rcnt_d = '0;
      evt_d  = rise && m != KM_RELEASE;
    end else if (fall) begin
      st_d   = ST_UP;
      rcnt_d = '0;
      evt_d  = m == KM_RELEASE || m == KM_BOTH;
    end else if (m != KM_REPEAT) begin
      st_d   = ST_DOWN;
      rcnt_d = '0;
    end else if (rep_hit) begin
      st_d   = ST_REPEAT;
      rcnt_d = '0;
      evt_d  = 1'b1;
    end else begin
      rcnt_d = rcnt_q + RW'(1);
    end
  end
  // state registers; sync flops reset to the released value so reset exit never looks like a press
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      level_q <= 1'b0;
      evt_q   <= 1'b0;
      st_q    <= ST_UP;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
      level_q <= level_d;
      evt_q   <= evt_d;
      st_q    <= st_d;
    end
  end
  assign level = level_q;
  assign evt   = evt_q;
endmodule

// File: rtl/key_events.sv
// key_events: N_KEYS independent key conditioners plus an any-event flag
module key_events
  import key_events_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 50,
  parameter int REPEAT_PERIOD   = 10,
  parameter int ACTIVE_LOW_IN   = 1
) (
  input logic          clk,
  input logic          reset,
  key_events_if.slave  bus
);
  logic [N_KEYS-1:0] level_w, evt_w;
  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_channel #(
      .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD), .ACTIVE_LOW_IN(ACTIVE_LOW_IN)
    ) u_ch (
      .clk(clk), .reset(reset), .key(bus.key[i]), .mode(bus.mode[2*i+:2]),
      .level(level_w[i]), .evt(evt_w[i])
    );
  end
  assign bus.level   = level_w;
  assign bus.evt     = evt_w;
  assign bus.any_evt = |evt_w;
endmodule
